fpu_mul_arbiter: RTL and testbench

- Shares one single-precision multiplier core between NREQ independent requesters.
- Each requester presents two operands with a request line. The arbiter selects one requester round-robin, issues the operation to the core, waits for the core's ready pulse, and returns the result with a per-port done pulse.
- Sits between the FPU front-end issue ports and the multiplier core.
- A watchdog keeps a hung core from stalling all requesters.

---
 rtl/fpu_mul_arbiter.sv | 117 +++++++++++
 tb/tb_fpu_mul_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier core among NREQ requesters.
// One op outstanding at a time; a watchdog abandons a hung op with a quiet-NaN result.
module fpu_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*32-1:0] opa,
  input  logic [NREQ*32-1:0] opb,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [31:0]        res,
  output logic [31:0]        mul_din1,
  output logic [31:0]        mul_din2,
  output logic               mul_dval,
  input  logic [31:0]        mul_result,
  input  logic               mul_rdy,
  output logic               busy,
  output logic               timeout_err
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, owner, pick;
  logic [WW-1:0]   wdog;
  logic            found;
  logic            do_grant, do_finish, do_tout;

  // First requesting port at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    do_grant  = 1'b0;
    do_finish = 1'b0;
    do_tout   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          do_grant = 1'b1;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        // A result arriving on the last watchdog cycle still counts as success.
        if (mul_rdy) begin
          do_finish = 1'b1;
          state_n   = IDLE;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          do_finish = 1'b1;
          do_tout   = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      done        <= '0;
      res         <= '0;
      mul_din1    <= '0;
      mul_din2    <= '0;
      mul_dval    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      owner       <= '0;
      wdog        <= '0;
    end else begin
      gnt      <= '0;
      done     <= '0;
      mul_dval <= 1'b0;
      busy     <= (state_n != IDLE);
      if (do_grant) begin
        gnt      <= NREQ'(1) << pick;
        mul_dval <= 1'b1;
        mul_din1 <= opa[pick*32 +: 32];
        mul_din2 <= opb[pick*32 +: 32];
        owner    <= pick;
        wdog     <= '0;
      end else if (state == WAIT) begin
        wdog <= wdog + 1'b1;
      end
      if (do_finish) begin
        done <= NREQ'(1) << owner;
        res  <= do_tout ? QNAN : mul_result;
        ptr  <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
      if (do_tout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Scoreboard bench for fpu_mul_arbiter with a behavioural multiplier stub.
module tb_fpu_mul_arbiter;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] opa, opb;
  logic [NREQ-1:0]    gnt, done;
  logic [31:0]        res, mul_din1, mul_din2, mul_result;
  logic               mul_dval, mul_rdy, busy, timeout_err;

  fpu_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb),
    .gnt(gnt), .done(done), .res(res),
    .mul_din1(mul_din1), .mul_din2(mul_din2), .mul_dval(mul_dval),
    .mul_result(mul_result), .mul_rdy(mul_rdy),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int port; logic [31:0] a; logic [31:0] b; } gexp_t;
  typedef struct { int port; logic [31:0] r; } dexp_t;
  gexp_t gq[$];
  dexp_t dq[$];

  int n_cmp = 0, n_bad = 0;
  int ngnt = 0, ndone = 0, cyc = 0;
  int dval_cyc = 0, done_cyc = 0, rdy_cyc = 0;
  bit outstanding = 1'b0;
  bit hung = 1'b0;
  int stray_n = 0, stray_seen = 0;
  logic [NREQ-1:0] hold;
  int reraise [NREQ];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] core_f(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:0] == 31'h7F80_0000 && b[30:0] == 31'h0) ||
        (b[30:0] == 31'h7F80_0000 && a[30:0] == 31'h0)) return QNAN;
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a ^ b;
  endfunction

  always @(posedge clk) cyc++;

  // Multiplier core stub: 3-cycle result unless hung; can inject a stray rdy.
  logic [31:0] sa, sb;
  bit pend;
  int cnt;
  initial begin
    mul_rdy = 1'b0; mul_result = '0; pend = 1'b0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      mul_rdy = 1'b0;
      if (!rst_n) pend = 1'b0;
      else if (stray_seen != stray_n) begin
        stray_seen = stray_n;
        mul_result = 32'h1234_5678;
        mul_rdy = 1'b1;
      end else begin
        if (mul_dval && !hung) begin
          pend = 1'b1; cnt = 2; sa = mul_din1; sb = mul_din2;
        end
        if (pend) begin
          if (cnt == 0) begin
            mul_result = core_f(sa, sb);
            mul_rdy = 1'b1;
            pend = 1'b0;
          end else cnt--;
        end
      end
    end
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    gexp_t g;
    dexp_t d;
    logic [NREQ-1:0] oh;
    if (!rst_n) outstanding = 1'b0;
    else begin
      if (gnt != '0) begin
        ngnt++;
        dval_cyc = cyc;
        chk("busy_at_gnt", busy, 1);
        chk("dval_with_gnt", mul_dval, 1);
        chk("single_outstanding", outstanding, 0);
        outstanding = 1'b1;
        if (gq.size() == 0) chk("unexpected_gnt", gnt, 0);
        else begin
          g = gq.pop_front();
          oh = NREQ'(1) << g.port;
          chk("gnt_port", gnt, oh);
          chk("din1", mul_din1, g.a);
          chk("din2", mul_din2, g.b);
        end
      end else if (mul_dval) chk("dval_without_gnt", mul_dval, 0);
      if (mul_rdy) begin
        outstanding = 1'b0;
        rdy_cyc = cyc;
      end
      if (done != '0) begin
        ndone++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
        if (dq.size() == 0) chk("unexpected_done", done, 0);
        else begin
          d = dq.pop_front();
          oh = NREQ'(1) << d.port;
          chk("done_port", done, oh);
          chk("res", res, d.r);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    for (int p = 0; p < NREQ; p++) begin
      if (gnt[p] && !hold[p]) req[p] = 1'b0;
      if (done[p] && reraise[p] > 0) begin
        req[p] = 1'b1;
        reraise[p]--;
      end
    end
  endtask

  task automatic wait_gnt(input int target, input int budget);
    int k = 0;
    while (ngnt < target && k < budget) begin tick(); k++; end
    chk("wait_gnt", ngnt, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (ndone < target && k < budget) begin tick(); k++; end
    chk("wait_done", ndone, target);
  endtask

  task automatic set_ops(input int p, input logic [31:0] a, input logic [31:0] b);
    opa[p*32 +: 32] = a;
    opb[p*32 +: 32] = b;
  endtask

  task automatic expect_op(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input bit with_done);
    gexp_t g;
    dexp_t d;
    g.port = p; g.a = a; g.b = b;
    gq.push_back(g);
    if (with_done) begin
      d.port = p; d.r = r;
      dq.push_back(d);
    end
  endtask

  initial begin
    int t0, base;
    logic [31:0] ca [NREQ];
    logic [31:0] cb [NREQ];
    rst_n = 1'b0; req = '0; opa = '0; opb = '0; hold = '0;
    for (int p = 0; p < NREQ; p++) reraise[p] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_dval", mul_dval, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_din1", mul_din1, 0);
    rst_n = 1'b1;
    tick();

    // Single request on port 2.
    base = ndone;
    set_ops(2, 32'h4000_0000, 32'h4040_0000);
    expect_op(2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1);
    req[2] = 1'b1;
    t0 = cyc;
    wait_done(base + 1, 40);
    chk("gnt_latency", dval_cyc - t0, 1);
    chk("done_latency", done_cyc - rdy_cyc, 1);

    // Inf x 0 through the core on port 3 (leaves ptr at 0).
    base = ndone;
    set_ops(3, 32'h7F80_0000, 32'h0000_0000);
    expect_op(3, 32'h7F80_0000, 32'h0000_0000, QNAN, 1);
    req[3] = 1'b1;
    wait_done(base + 1, 40);
    chk("special_no_terr", timeout_err, 0);

    // Contention: all four ports, port 0 issues twice.
    base = ndone;
    for (int p = 0; p < NREQ; p++) begin
      ca[p] = 32'h3F80_0000 + p;
      cb[p] = 32'h0001_0000 << p;
      set_ops(p, ca[p], cb[p]);
    end
    for (int p = 0; p < NREQ; p++) expect_op(p, ca[p], cb[p], ca[p] ^ cb[p], 1);
    expect_op(0, ca[0], cb[0], ca[0] ^ cb[0], 1);
    reraise[0] = 1;
    req = '1;
    wait_done(base + 5, 200);

    // Fairness: port 0 held, port 3 arrives during port 0's WAIT.
    base = ndone;
    t0 = ngnt;
    hold[0] = 1'b1;
    expect_op(0, ca[0], cb[0], ca[0] ^ cb[0], 1);
    expect_op(3, ca[3], cb[3], ca[3] ^ cb[3], 1);
    expect_op(0, ca[0], cb[0], ca[0] ^ cb[0], 1);
    req[0] = 1'b1;
    wait_gnt(t0 + 1, 20);
    req[3] = 1'b1;
    wait_gnt(t0 + 3, 60);
    hold[0] = 1'b0;
    req[0] = 1'b0;
    wait_done(base + 3, 60);

    // Watchdog on a hung core.
    base = ndone;
    hung = 1'b1;
    set_ops(1, 32'h3F00_0000, 32'h4100_0000);
    expect_op(1, 32'h3F00_0000, 32'h4100_0000, QNAN, 1);
    req[1] = 1'b1;
    wait_done(base + 1, 120);
    chk("wd_latency", done_cyc - dval_cyc, TIMEOUT);
    chk("wd_terr", timeout_err, 1);
    repeat (5) tick();
    chk("wd_terr_sticky", timeout_err, 1);
    stray_n++;
    repeat (5) tick();
    chk("stray_res", res, QNAN);
    chk("stray_no_done", ndone, base + 1);
    chk("stray_busy", busy, 0);
    chk("stray_terr", timeout_err, 1);

    // Asynchronous reset in the middle of a WAIT.
    base = ndone;
    t0 = ngnt;
    set_ops(3, 32'h4080_0000, 32'h4080_0000);
    expect_op(3, 32'h4080_0000, 32'h4080_0000, 32'h0, 0);
    req[3] = 1'b1;
    wait_gnt(t0 + 1, 20);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_done", done, 0);
    chk("arst_res", res, 0);
    chk("arst_dval", mul_dval, 0);
    chk("arst_busy", busy, 0);
    chk("arst_terr", timeout_err, 0);
    chk("arst_din1", mul_din1, 0);
    chk("arst_din2", mul_din2, 0);
    req = '0;
    hung = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("arst_no_done", ndone, base);

    // ptr restarts at 0: port 1 wins over port 3.
    set_ops(1, 32'h4000_0000, 32'h3F80_0000);
    set_ops(3, 32'h4040_0000, 32'h4000_0000);
    expect_op(1, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000 ^ 32'h3F80_0000, 1);
    expect_op(3, 32'h4040_0000, 32'h4000_0000, 32'h4040_0000 ^ 32'h4000_0000, 1);
    req[1] = 1'b1;
    req[3] = 1'b1;
    wait_done(base + 2, 60);

    repeat (4) tick();
    chk("gq_empty", gq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
